// File: rtl/inst_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
// Format codes, base opcodes and the canonical NOP word.
package inst_enc_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h00000013;

endpackage

// File: rtl/inst_encoder_imm_pack.sv
// Combinational field packer: scatters immediate bits into format-specific slots.
// Optional immediate range checking is enabled by defining INST_ENC_RANGE_CHECK_EN.
module imm_pack
    import inst_enc_pkg::*;
(
    input  logic [2:0]  i_fmt,
    input  logic [6:0]  i_opcode,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [31:0] i_imm,
    output logic [31:0] o_inst,
    output logic        o_err
);

    logic w_range_err;

`ifdef INST_ENC_RANGE_CHECK_EN
    logic signed [31:0] w_simm;
    logic               w_fit12;
    logic               w_fit13;
    logic               w_fit21;

    assign w_simm  = $signed(i_imm);
    assign w_fit12 = (w_simm >= -32'sd2048)    && (w_simm <= 32'sd2047);
    assign w_fit13 = (w_simm >= -32'sd4096)    && (w_simm <= 32'sd4094);
    assign w_fit21 = (w_simm >= -32'sd1048576) && (w_simm <= 32'sd1048574);

    // Branch/jump offsets are halfword multiples, so bit 0 must be clear.
    always_comb begin
        w_range_err = 1'b0;
        case (i_fmt)
            FMT_I, FMT_S: w_range_err = !w_fit12;
            FMT_B:        w_range_err = !w_fit13 || i_imm[0];
            FMT_U:        w_range_err = |i_imm[11:0];
            FMT_J:        w_range_err = !w_fit21 || i_imm[0];
            default:      w_range_err = 1'b0;
        endcase
    end
`else
    assign w_range_err = 1'b0;
`endif

    always_comb begin
        o_inst = NOP_INST;
        o_err  = 1'b1;
        case (i_fmt)
            FMT_R: begin
                o_inst = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
                o_err  = 1'b0;
            end
            FMT_I: begin
                o_inst = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
                o_err  = w_range_err;
            end
            FMT_S: begin
                o_inst = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
                o_err  = w_range_err;
            end
            FMT_B: begin
                o_inst = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                          i_imm[4:1], i_imm[11], i_opcode};
                o_err  = w_range_err;
            end
            FMT_U: begin
                o_inst = {i_imm[31:12], i_rd, i_opcode};
                o_err  = w_range_err;
            end
            FMT_J: begin
                o_inst = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
                o_err  = w_range_err;
            end
            default: begin
                o_inst = NOP_INST;
                o_err  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Two-stage valid/ready RV32I instruction encoder with handoff/error counters.
// Immediate range checking is compiled in when INST_ENC_RANGE_CHECK_EN is defined.
module inst_encoder
    import inst_enc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_fmt,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             out_err,
    output logic [CNT_W-1:0] cnt_inst,
    output logic [CNT_W-1:0] cnt_err
);

    logic             r_s0_v;
    logic [2:0]       r_s0_fmt;
    logic [6:0]       r_s0_opcode;
    logic [4:0]       r_s0_rd;
    logic [4:0]       r_s0_rs1;
    logic [4:0]       r_s0_rs2;
    logic [2:0]       r_s0_funct3;
    logic [6:0]       r_s0_funct7;
    logic [31:0]      r_s0_imm;

    logic             r_s1_v;
    logic [31:0]      r_s1_inst;
    logic             r_s1_err;

    logic [CNT_W-1:0] r_cnt_inst;
    logic [CNT_W-1:0] r_cnt_err;

    logic             w_s1_rdy;
    logic             w_in_ready;
    logic             w_handoff;
    logic [31:0]      w_pack_inst;
    logic             w_pack_err;

    // A transfer happens on any rising edge where valid && ready; a stage
    // holds its contents while its downstream is not ready, so words are
    // never dropped, duplicated or reordered.
    assign w_s1_rdy   = !r_s1_v || out_ready;
    assign w_in_ready = rst_n && (!r_s0_v || w_s1_rdy);
    assign w_handoff  = r_s1_v && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0_v      <= 1'b0;
            r_s0_fmt    <= 3'd0;
            r_s0_opcode <= 7'd0;
            r_s0_rd     <= 5'd0;
            r_s0_rs1    <= 5'd0;
            r_s0_rs2    <= 5'd0;
            r_s0_funct3 <= 3'd0;
            r_s0_funct7 <= 7'd0;
            r_s0_imm    <= 32'd0;
        end else if (w_in_ready) begin
            r_s0_v <= in_valid;
            if (in_valid) begin
                r_s0_fmt    <= in_fmt;
                r_s0_opcode <= in_opcode;
                r_s0_rd     <= in_rd;
                r_s0_rs1    <= in_rs1;
                r_s0_rs2    <= in_rs2;
                r_s0_funct3 <= in_funct3;
                r_s0_funct7 <= in_funct7;
                r_s0_imm    <= in_imm;
            end
        end
    end

    imm_pack u_imm_pack (
        .i_fmt    (r_s0_fmt),
        .i_opcode (r_s0_opcode),
        .i_rd     (r_s0_rd),
        .i_rs1    (r_s0_rs1),
        .i_rs2    (r_s0_rs2),
        .i_funct3 (r_s0_funct3),
        .i_funct7 (r_s0_funct7),
        .i_imm    (r_s0_imm),
        .o_inst   (w_pack_inst),
        .o_err    (w_pack_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v    <= 1'b0;
            r_s1_inst <= 32'd0;
            r_s1_err  <= 1'b0;
        end else if (w_s1_rdy) begin
            r_s1_v <= r_s0_v;
            if (r_s0_v) begin
                r_s1_inst <= w_pack_inst;
                r_s1_err  <= w_pack_err;
            end
        end
    end

    // Counters advance only on an actual handoff and wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_inst <= '0;
            r_cnt_err  <= '0;
        end else if (w_handoff) begin
            r_cnt_inst <= r_cnt_inst + CNT_W'(1);
            if (r_s1_err) begin
                r_cnt_err <= r_cnt_err + CNT_W'(1);
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_s1_v;
    assign out_inst  = r_s1_inst;
    assign out_err   = r_s1_err;
    assign cnt_inst  = r_cnt_inst;
    assign cnt_err   = r_cnt_err;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed vectors, stall, random traffic, mid-flight reset.
// Expectations follow INST_ENC_RANGE_CHECK_EN the same way the design build does.
module tb_inst_encoder;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_fmt;
    logic [6:0]       in_opcode;
    logic [4:0]       in_rd;
    logic [4:0]       in_rs1;
    logic [4:0]       in_rs2;
    logic [2:0]       in_funct3;
    logic [6:0]       in_funct7;
    logic [31:0]      in_imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_inst;
    logic             out_err;
    logic [CNT_W-1:0] cnt_inst;
    logic [CNT_W-1:0] cnt_err;

    int               checks = 0;
    int               errors = 0;
    logic [32:0]      exp_q[$];
    logic [CNT_W-1:0] mdl_cnt_inst = '0;
    logic [CNT_W-1:0] mdl_cnt_err  = '0;
    int               bnd[14] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095,
                                  -1048577, -1048576, 1048574, 1048575, 4096, -6};

    inst_encoder #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_err   (out_err),
        .cnt_inst  (cnt_inst),
        .cnt_err   (cnt_err)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Builds the word by adding each field at its bit offset; returns {err, inst}.
    function automatic logic [32:0] ref_encode(input logic [2:0] fmt, input logic [6:0] op,
                                               input logic [4:0] rd, input logic [4:0] rs1,
                                               input logic [4:0] rs2, input logic [2:0] f3,
                                               input logic [6:0] f7, input logic [31:0] imm);
        logic [31:0] w;
        logic [31:0] base;
        logic        e;
        int          s;
        s    = $signed(imm);
        base = 32'(op) | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15);
        e    = 1'b0;
        case (fmt)
            3'd0: w = base | (32'(rs2) << 20) | (32'(f7) << 25);
            3'd1: w = base | ((imm & 32'hFFF) << 20);
            3'd2: w = 32'(op) | ((imm & 32'h1F) << 7) | (32'(f3) << 12) | (32'(rs1) << 15)
                      | (32'(rs2) << 20) | (((imm >> 5) & 32'h7F) << 25);
            3'd3: w = 32'(op) | (((imm >> 11) & 32'h1) << 7) | (((imm >> 1) & 32'hF) << 8)
                      | (32'(f3) << 12) | (32'(rs1) << 15) | (32'(rs2) << 20)
                      | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 12) & 32'h1) << 31);
            3'd4: w = 32'(op) | (32'(rd) << 7) | (imm & 32'hFFFFF000);
            3'd5: w = 32'(op) | (32'(rd) << 7) | (((imm >> 12) & 32'hFF) << 12)
                      | (((imm >> 11) & 32'h1) << 20) | (((imm >> 1) & 32'h3FF) << 21)
                      | (((imm >> 20) & 32'h1) << 31);
            default: begin
                w = 32'h00000013;
                e = 1'b1;
            end
        endcase
`ifdef INST_ENC_RANGE_CHECK_EN
        case (fmt)
            3'd1, 3'd2: e = (s < -2048) || (s > 2047);
            3'd3:       e = (s < -4096) || (s > 4094) || (imm[0] != 1'b0);
            3'd4:       e = (imm % 4096) != 0;
            3'd5:       e = (s < -1048576) || (s > 1048574) || (imm[0] != 1'b0);
            default:    ;
        endcase
`else
        if (s == 0) e = e;
`endif
        return {e, w};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_bundle(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] imm);
        in_fmt    = fmt;
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
    endtask

    task automatic rand_bundle();
        logic [31:0] imm;
        case ($urandom_range(0, 4))
            0:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            1:       imm = 32'(bnd[$urandom_range(0, 13)]);
            2:       imm = $urandom() & 32'hFFFFF000;
            3:       imm = 32'($urandom_range(0, 4194303)) - 32'd2097152;
            default: imm = $urandom();
        endcase
        drive_bundle(3'($urandom_range(0, 7)), 7'($urandom()), 5'($urandom()), 5'($urandom()),
                     5'($urandom()), 3'($urandom()), 7'($urandom()), imm);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive_bundle(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0h want 0", out_valid); end
        checks++; if (out_inst !== 32'd0) begin errors++; $display("FAIL reset_out_inst got %08h want 00000000", out_inst); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got %0h want 0", out_err); end
        checks++; if (cnt_inst !== '0 || cnt_err !== '0) begin errors++; $display("FAIL reset_counters got %0d/%0d want 0/0", cnt_inst, cnt_err); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low got %0h want 0", in_ready); end
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_high got %0h want 1", in_ready); end
    endtask

    task automatic test_directed();
        logic [2:0]  t_fmt[6]  = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd7, 3'd1};
        logic [6:0]  t_op[6]   = '{7'b0010011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b0110011, 7'b0010011};
        logic [4:0]  t_rd[6]   = '{5'd1, 5'd0, 5'd0, 5'd1, 5'd3, 5'd1};
        logic [4:0]  t_rs1[6]  = '{5'd0, 5'd1, 5'd1, 5'd0, 5'd4, 5'd0};
        logic [4:0]  t_rs2[6]  = '{5'd0, 5'd2, 5'd2, 5'd0, 5'd5, 5'd0};
        logic [2:0]  t_f3[6]   = '{3'd0, 3'd2, 3'd0, 3'd0, 3'd1, 3'd0};
        logic [31:0] t_imm[6]  = '{32'd5, 32'd8, 32'hFFFFFFFC, 32'd2048, 32'd0, 32'd2048};
        logic [31:0] t_inst[6] = '{32'h00500093, 32'h0020A423, 32'hFE208EE3, 32'h001000EF,
                                   32'h00000013, 32'h80000093};
`ifdef INST_ENC_RANGE_CHECK_EN
        logic        t_err[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`else
        logic        t_err[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`endif
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive_bundle(t_fmt[i], t_op[i], t_rd[i], t_rs1[i], t_rs2[i], t_f3[i], 7'd0, t_imm[i]);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_in_ready got %0h want 1", i, in_ready); end
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_early_valid got %0h want 0", i, out_valid); end
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dir%0d_out_valid got %0h want 1", i, out_valid); end
            checks++; if (out_inst !== t_inst[i]) begin errors++; $display("FAIL dir%0d_inst got %08h want %08h", i, out_inst, t_inst[i]); end
            checks++; if (out_err !== t_err[i]) begin errors++; $display("FAIL dir%0d_err got %0h want %0h", i, out_err, t_err[i]); end
            mdl_cnt_inst = mdl_cnt_inst + 1'b1;
            mdl_cnt_err  = mdl_cnt_err + CNT_W'(t_err[i]);
            @(negedge clk);
            checks++; if (cnt_inst !== mdl_cnt_inst || cnt_err !== mdl_cnt_err) begin
                errors++; $display("FAIL dir%0d_counters got %0d/%0d want %0d/%0d", i, cnt_inst, cnt_err, mdl_cnt_inst, mdl_cnt_err);
            end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_drained got %0h want 0", i, out_valid); end
        end
    endtask

    task automatic test_stall();
        logic [32:0] e[3];
        logic [2:0]  fm[3]  = '{3'd1, 3'd0, 3'd4};
        logic [31:0] im[3]  = '{32'd100, 32'd0, 32'h12345000};
        int          accepted = 0;
        int          popped   = 0;
        logic        fire;
        for (int j = 0; j < 3; j++) e[j] = ref_encode(fm[j], 7'h13 + 7'(j), 5'(j + 2), 5'(j + 7), 5'(j + 9), 3'(j), 7'(j), im[j]);
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            drive_bundle(fm[accepted], 7'h13 + 7'(accepted), 5'(accepted + 2), 5'(accepted + 7),
                         5'(accepted + 9), 3'(accepted), 7'(accepted), im[accepted]);
            in_valid = 1'b1;
            #1;
            fire = in_ready;
            if (out_valid) begin
                checks++; if (out_inst !== e[0][31:0]) begin errors++; $display("FAIL stall_hold_c%0d got %08h want %08h", c, out_inst, e[0][31:0]); end
            end
            @(posedge clk);
            if (fire) accepted++;
        end
        @(negedge clk);
        #1;
        checks++; if (accepted != 2) begin errors++; $display("FAIL stall_accepts got %0d want 2", accepted); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %0h want 0", in_ready); end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && popped < 3; c++) begin
            if (c > 0) @(negedge clk);
            if (accepted < 3) begin
                drive_bundle(fm[accepted], 7'h13 + 7'(accepted), 5'(accepted + 2), 5'(accepted + 7),
                             5'(accepted + 9), 3'(accepted), 7'(accepted), im[accepted]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            fire = in_valid && in_ready;
            if (out_valid) begin
                checks++; if ({out_err, out_inst} !== e[popped]) begin
                    errors++; $display("FAIL stall_order%0d got %0h_%08h want %0h_%08h", popped, out_err, out_inst, e[popped][32], e[popped][31:0]);
                end
                mdl_cnt_inst = mdl_cnt_inst + 1'b1;
                mdl_cnt_err  = mdl_cnt_err + CNT_W'(e[popped][32]);
                popped++;
            end
            @(posedge clk);
            if (fire) accepted++;
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (popped != 3) begin errors++; $display("FAIL stall_drain got %0d want 3", popped); end
        checks++; if (cnt_inst !== mdl_cnt_inst || cnt_err !== mdl_cnt_err) begin
            errors++; $display("FAIL stall_counters got %0d/%0d want %0d/%0d", cnt_inst, cnt_err, mdl_cnt_inst, mdl_cnt_err);
        end
    endtask

    task automatic test_random();
        logic        hold = 1'b0;
        logic [32:0] exp;
        logic        fire_in;
        for (int c = 0; c < 400 + 12; c++) begin
            @(negedge clk);
            if (c >= 400) begin
                in_valid  = hold;
                out_ready = 1'b1;
            end else begin
                if (!hold) begin
                    in_valid = ($urandom_range(0, 3) != 0);
                    rand_bundle();
                end
                out_ready = ($urandom_range(0, 2) != 0);
            end
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++; $display("FAIL rand_unexpected_word got %08h want none", out_inst);
                end else begin
                    exp = exp_q.pop_front();
                    checks++; if ({out_err, out_inst} !== exp) begin
                        errors++; $display("FAIL rand_word c%0d got %0h_%08h want %0h_%08h", c, out_err, out_inst, exp[32], exp[31:0]);
                    end
                    mdl_cnt_inst = mdl_cnt_inst + 1'b1;
                    mdl_cnt_err  = mdl_cnt_err + CNT_W'(exp[32]);
                end
            end
            fire_in = in_valid && in_ready;
            if (fire_in) exp_q.push_back(ref_encode(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm));
            hold = in_valid && !in_ready;
            @(posedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_leftover got %0d want 0", exp_q.size()); end
        checks++; if (cnt_inst !== mdl_cnt_inst || cnt_err !== mdl_cnt_err) begin
            errors++; $display("FAIL rand_counters got %0d/%0d want %0d/%0d", cnt_inst, cnt_err, mdl_cnt_inst, mdl_cnt_err);
        end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rand_bundle();
        @(negedge clk);
        rand_bundle();
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL midrst_full got valid=%0h ready=%0h want 1/0", out_valid, in_ready);
        end
        rst_n = 1'b0;
        #1;
        mdl_cnt_inst = '0;
        mdl_cnt_err  = '0;
        exp_q.delete();
        checks++; if (out_valid !== 1'b0 || out_inst !== 32'd0 || out_err !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs got %0h/%08h/%0h want 0/00000000/0", out_valid, out_inst, out_err);
        end
        checks++; if (cnt_inst !== mdl_cnt_inst || cnt_err !== mdl_cnt_err) begin
            errors++; $display("FAIL midrst_counters got %0d/%0d want 0/0", cnt_inst, cnt_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %0h want 1", in_ready); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale_c%0d got %0h want 0", c, out_valid); end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_random();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

endmodule
